// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU front end.
//   ADDR_W           - program counter / instruction-memory word-address width
//   INSTR_W          - instruction width
//   RESET_PC_DEFAULT - default PC value loaded on reset
//   fetch_state_e    - fetch_unit state encoding
//   pc_inc()         - PC increment, wrapping modulo 2^ADDR_W
package cpu_pkg;

  localparam int ADDR_W  = 24;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_REQ  = 2'd1,  // request outstanding, data wanted
    S_DROP = 2'd2,  // request outstanding, data to be discarded (redirected)
    S_DEC  = 2'd3   // fetched word presented to the decoder
  } fetch_state_e;

  // The carry out of the top bit is dropped, so FFFFFF + 1 gives 000000.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
    return p + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read bus (req/ack handshake).
//   imem_req   - read request, held until the cycle after imem_ack
//   imem_addr  - word address, stable while imem_req is high
//   imem_rdata - read data, valid while imem_ack is high
//   imem_ack   - read complete; may be high in the first imem_req cycle
// Modports: master = fetch side, slave = memory side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (output imem_req, output imem_addr,
                  input  imem_rdata, input imem_ack);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decoder_cpu.
// Holds the PC, fetches one word per request over the imem bus, and presents
// it on code with a one-cycle en_de strobe. Jumps redirect the PC; a request
// that is in flight when a jump arrives is completed and its data is dropped.
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   stall      - downstream not ready; gates issuing a new fetch
//   jump_en    - one-cycle redirect request
//   jump_addr  - redirect target (word address)
//   imem       - instruction-memory bus (master side)
//   code       - last accepted instruction word
//   en_de      - one-cycle strobe: code holds a new instruction
//   pc         - address of the next instruction to fetch
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] code,
  output logic               en_de,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic               imem_req_q;
  logic [INSTR_W-1:0] code_q;
  logic               en_de_q;

  // Next-PC mux: a jump beats the increment in every state; the increment
  // happens only when requested data is accepted.
  always_comb begin
    pc_d = pc_q;
    if (jump_en) begin
      pc_d = jump_addr;
    end else if (state_q == S_REQ && imem.imem_ack) begin
      pc_d = pc_inc(pc_q);
    end
  end

  // NOTE: all state here is assigned with <= so every register samples the
  // values from before this edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      code_q      <= '0;
      en_de_q     <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      en_de_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!stall) begin
            // pc_d, not pc_q, so a jump in this cycle is fetched immediately.
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_d;
          end
        end
        S_REQ: begin
          if (imem.imem_ack) begin
            imem_req_q <= 1'b0;
            if (jump_en) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DEC;
              code_q  <= imem.imem_rdata;
              en_de_q <= 1'b1;
            end
          end else if (jump_en) begin
            // The memory still owes us this word; keep the request up at the
            // old address and throw the data away when it arrives.
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem.imem_ack) begin
            state_q    <= S_IDLE;
            imem_req_q <= 1'b0;
          end
        end
        S_DEC: begin
          if (stall) begin
            state_q <= S_IDLE;
          end else begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign code           = code_q;
  assign en_de          = en_de_q;
  assign pc             = pc_q;

endmodule
